// File: rtl/seven_segment_scan_decoder.sv
// Readback of the multiplexed seven-segment bus: synchronises an/seg, waits for a
// stable window per (anode, pattern) pair, decodes it and stores the digit per position.
module seven_segment_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        capture_stb,
  output logic [1:0]  capture_idx,
  output logic        changed,
  output logic        err_an
);

  // state  | meaning
  // IDLE   | an not one-hot-low (idle bus or multi-low error)
  // SETTLE | one-hot-low, stability window still running
  // HOLD   | pair captured, waiting for any input change
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  function automatic logic onehot_low(input logic [3:0] a);
    return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
  endfunction

  function automatic logic multi_low(input logic [3:0] a);
    return (a != 4'b1111) && !onehot_low(a);
  endfunction

  function automatic logic [3:0] decode(input logic [6:0] s);
    logic [3:0] d;
    case (s)
      7'b1000000: d = 4'h0;
      7'b1111001: d = 4'h1;
      7'b0100100: d = 4'h2;
      7'b0110000: d = 4'h3;
      7'b0011001: d = 4'h4;
      7'b0010010: d = 4'h5;
      7'b0000010: d = 4'h6;
      7'b1111000: d = 4'h7;
      7'b0000000: d = 4'h8;
      7'b0010000: d = 4'h9;
      7'b1111111: d = 4'hF;
      default:    d = 4'hE;
    endcase
    return d;
  endfunction

  // bus vectors are {an, seg}
  logic [10:0] bus_s1_q, bus_s2_q, bus_prev_q;
  logic [7:0]  cnt_q, cnt_d;
  state_t      state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  valid_q, valid_d;
  logic        stb_q, stb_d;
  logic [1:0]  idx_q, idx_d;
  logic        changed_q, changed_d;
  logic        err_q, err_d;

  logic [3:0]  an_s2;
  logic [6:0]  seg_s2;
  logic        change, is_onehot, capture;
  logic [1:0]  pos;
  logic [3:0]  nib, old_nib;

  always_comb begin
    an_s2     = bus_s2_q[10:7];
    seg_s2    = bus_s2_q[6:0];
    change    = (bus_s2_q != bus_prev_q);
    is_onehot = onehot_low(an_s2);
    pos       = 2'd0;
    case (an_s2)
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: pos = 2'd0;
    endcase
    nib     = decode(seg_s2);
    old_nib = digits_q[{pos, 2'b00} +: 4];

    if (change)                cnt_d = 8'd0;
    else if (cnt_q >= STABLE_C) cnt_d = STABLE_C;
    else                       cnt_d = cnt_q + 8'd1;

    state_d = state_q;
    capture = 1'b0;
    if (!is_onehot) begin
      state_d = IDLE;
    end else if (change) begin
      state_d = SETTLE;
    end else begin
      case (state_q)
        IDLE:    state_d = SETTLE;
        SETTLE: begin
          if (cnt_d == STABLE_C) begin
            state_d = HOLD;
            capture = 1'b1;
          end
        end
        HOLD:    state_d = HOLD;
        default: state_d = IDLE;
      endcase
    end

    digits_d  = digits_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    stb_d     = capture;
    changed_d = 1'b0;
    if (capture) begin
      digits_d[{pos, 2'b00} +: 4] = nib;
      valid_d[pos] = 1'b1;
      idx_d     = pos;
      changed_d = (nib != old_nib);
    end

    // flag on the edge the pattern enters s2
    err_d = err_q | multi_low(bus_s1_q[10:7]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_s1_q   <= '1;
      bus_s2_q   <= '1;
      bus_prev_q <= '1;
      cnt_q      <= 8'd0;
      state_q    <= IDLE;
      digits_q   <= 16'hFFFF;
      valid_q    <= 4'd0;
      stb_q      <= 1'b0;
      idx_q      <= 2'd0;
      changed_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      bus_s1_q   <= {an, seg};
      bus_s2_q   <= bus_s1_q;
      bus_prev_q <= bus_s2_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      stb_q      <= stb_d;
      idx_q      <= idx_d;
      changed_q  <= changed_d;
      err_q      <= err_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign capture_stb = stb_q;
  assign capture_idx = idx_q;
  assign changed     = changed_q;
  assign err_an      = err_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed bench for seven_segment_scan_decoder: expected captures go into a queue,
// a negedge monitor pops and checks each strobe (cycle, position, code, changed).
module tb_seven_segment_scan_decoder;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        capture_stb;
  logic [1:0]  capture_idx;
  logic        changed;
  logic        err_an;

  seven_segment_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an),
    .digits(digits), .digit_valid(digit_valid),
    .capture_stb(capture_stb), .capture_idx(capture_idx),
    .changed(changed), .err_an(err_an)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         at;
    logic [1:0] idx;
    logic [3:0] nib;
    logic       ch;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: checks every strobe against the queue head
  always @(negedge clk) begin
    if (capture_stb) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got idx %0d code %h expected no strobe (cycle %0d)",
                 capture_idx, digits[{capture_idx, 2'b00} +: 4], cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_cycle", cyc, e.at);
        check("capture_idx", {30'd0, capture_idx}, {30'd0, e.idx});
        check("digit_code", {28'd0, digits[{capture_idx, 2'b00} +: 4]}, {28'd0, e.nib});
        check("changed", {31'd0, changed}, {31'd0, e.ch});
        check("valid_bit", {31'd0, digit_valid[e.idx]}, 32'd1);
      end
    end else if (exp_q.size() != 0 && exp_q[0].at < cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missed_strobe: got none expected at cycle %0d (now %0d)", e.at, cyc);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // drive a pair at a negedge; optionally expect its capture S+2 edges after the next edge
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int hold,
                       input logic exp_cap, input logic [1:0] idx,
                       input logic [3:0] nib, input logic ch);
    an  = a;
    seg = s;
    if (exp_cap) exp_q.push_back('{cyc + S + 3, idx, nib, ch});
    wait_cycles(hold);
  endtask

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100,
                         P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010,
                         P8 = 7'b0000000, PB = 7'b1111111, PX = 7'b1010101;

  initial begin
    rst = 1'b1;
    an  = 4'hF;
    seg = PB;
    @(negedge clk);
    wait_cycles(2);
    rst = 1'b0;
    check("rst_digits", {16'd0, digits}, 32'h0000FFFF);
    check("rst_valid", {28'd0, digit_valid}, 32'd0);
    check("rst_idx", {30'd0, capture_idx}, 32'd0);
    check("rst_err", {31'd0, err_an}, 32'd0);
    check("rst_stb", {31'd0, capture_stb}, 32'd0);
    wait_cycles(20);

    // single capture, then long steady hold must not re-capture
    drive(4'b1110, P5, 100, 1'b1, 2'd0, 4'h5, 1'b1);
    check("single_valid", {28'd0, digit_valid}, 32'h1);
    check("single_digits", {16'd0, digits}, 32'h0000FFF5);
    drive(4'hF, PB, 5, 1'b0, 2'd0, 4'h0, 1'b0);

    // scan frame, zero-cycle gaps between positions
    drive(4'b1110, P1, 8, 1'b1, 2'd0, 4'h1, 1'b1);
    drive(4'b1101, P2, 8, 1'b1, 2'd1, 4'h2, 1'b1);
    drive(4'b1011, P3, 8, 1'b1, 2'd2, 4'h3, 1'b1);
    drive(4'b0111, P4, 8, 1'b1, 2'd3, 4'h4, 1'b1);
    check("scan_digits", {16'd0, digits}, 32'h00004321);
    check("scan_valid", {28'd0, digit_valid}, 32'hF);
    drive(4'b1110, P1, 8, 1'b1, 2'd0, 4'h1, 1'b0);
    drive(4'b1101, P2, 8, 1'b1, 2'd1, 4'h2, 1'b0);
    drive(4'b1011, P3, 8, 1'b1, 2'd2, 4'h3, 1'b0);
    drive(4'b0111, P4, 8, 1'b1, 2'd3, 4'h4, 1'b0);
    check("repeat_digits", {16'd0, digits}, 32'h00004321);

    // glitching segments never settle
    for (int i = 0; i < 10; i++)
      drive(4'b1110, (i % 2 == 0) ? P0 : P1, 3, 1'b0, 2'd0, 4'h0, 1'b0);
    check("glitch_digits", {16'd0, digits}, 32'h00004321);
    drive(4'b1110, P8, 10, 1'b1, 2'd0, 4'h8, 1'b1);
    check("glitch_then_8", {28'd0, digits[3:0]}, 32'h8);

    // multi-low anode: sticky error, no capture
    an  = 4'b1100;
    seg = P8;
    @(negedge clk);
    check("err_after_1_edge", {31'd0, err_an}, 32'd0);
    @(negedge clk);
    check("err_after_2_edges", {31'd0, err_an}, 32'd1);
    wait_cycles(10);
    drive(4'b1110, P8, 10, 1'b1, 2'd0, 4'h8, 1'b0);
    check("err_sticky", {31'd0, err_an}, 32'd1);
    drive(4'b1011, PX, 10, 1'b1, 2'd2, 4'hE, 1'b1);
    check("unknown_code", {28'd0, digits[11:8]}, 32'hE);
    check("unknown_digits", {16'd0, digits}, 32'h00004E28);

    // reset in the middle of a settle window
    drive(4'hF, PB, 5, 1'b0, 2'd0, 4'h0, 1'b0);
    an  = 4'b1101;
    seg = P3;
    wait_cycles(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_digits", {16'd0, digits}, 32'h0000FFFF);
    check("midrst_valid", {28'd0, digit_valid}, 32'd0);
    check("midrst_err", {31'd0, err_an}, 32'd0);
    exp_q.push_back('{cyc + S + 3, 2'd1, 4'h3, 1'b1});
    wait_cycles(12);
    check("midrst_capture", {16'd0, digits}, 32'h0000FF3F);

    wait_cycles(20);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL leftover_expect: got none expected strobe at cycle %0d", e.at);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
